// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, drives imem and buffers fetched words for decode
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_en,
    output logic [31:0]                 imem_addr,
    input  logic [31:0]                 imem_data,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    output logic                        id_valid,
    input  logic                        id_ready,
    output logic [31:0]                 id_instr,
    output logic [31:0]                 id_pc,
    output logic                        halted,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
    state_t r_state, w_next;
    logic [31:0] r_pc;
    logic [31:0] r_buf_pc [FIFO_DEPTH];
    logic [31:0] r_buf_instr [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0] r_count;
    logic w_push, w_pop;
    logic [31:0] w_target;
    assign w_push = (r_state == RUN) && fetch_en && !redirect_valid && (r_count < DEPTH);
    assign w_pop = id_valid && id_ready && !redirect_valid;
    assign w_target = redirect_pc & ~32'h3;
    assign id_valid = r_count != '0;
    assign id_instr = id_valid ? r_buf_instr[r_rd] : '0;
    assign id_pc = id_valid ? r_buf_pc[r_rd] : '0;
    assign halted = r_state == HALTED;
    assign fifo_count = r_count;
    assign imem_addr = r_pc;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = fetch_en ? RUN : IDLE;
            RUN:     w_next = !fetch_en ? IDLE : (w_push && imem_data == '0) ? HALTED : RUN;
            HALTED:  w_next = redirect_valid ? (fetch_en ? RUN : IDLE) : HALTED;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc <= RESET_PC;
            r_wr <= '0;
            r_rd <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (redirect_valid) begin
                r_pc <= w_target;
                r_wr <= '0;
                r_rd <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_pc <= r_pc + 32'd4;
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_pop) r_rd <= r_rd + 1'b1;
                r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            end
        end
    end
    // storage needs no reset: entries are only visible while counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wr] <= r_pc;
            r_buf_instr[r_wr] <= imem_data;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: random and directed checks of if_fetch_unit against a queue model
module tb_if_fetch_unit;
    logic clk = 0, rst_n = 0, fetch_en = 0, redirect_valid = 0, id_ready = 0;
    logic [31:0] redirect_pc = 0;
    logic [31:0] mem [64];
    logic [31:0] imem_addr, imem_data, id_instr, id_pc;
    logic id_valid, halted;
    logic [2:0] fifo_count;
    logic [31:0] imem_addr_w, imem_data_w, id_instr_w, id_pc_w;
    logic id_valid_w, halted_w;
    logic [2:0] fifo_count_w;
    int vectors = 0, errors = 0;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    ent_t q[$];
    ent_t got[$];
    logic [31:0] m_pc = 0;
    int m_st = 0;

    assign imem_data = mem[imem_addr[7:2]];
    assign imem_data_w = mem[imem_addr_w[7:2]];

    if_fetch_unit dut (.clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .halted(halted), .fifo_count(fifo_count));

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (.clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .imem_addr(imem_addr_w), .imem_data(imem_data_w), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid_w), .id_ready(id_ready), .id_instr(id_instr_w),
        .id_pc(id_pc_w), .halted(halted_w), .fifo_count(fifo_count_w));

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] epc, ein;
        epc = 0;
        ein = 0;
        if (q.size() != 0) begin
            epc = q[0].pc;
            ein = q[0].instr;
        end
        chk("id_valid", 32'(id_valid), 32'(q.size() != 0));
        chk("id_pc", id_pc, epc);
        chk("id_instr", id_instr, ein);
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("halted", 32'(halted), 32'(m_st == 2));
        chk("imem_addr", imem_addr, m_pc);
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = 0;
        m_st = 0;
    endtask

    // one clock: drive, check at negedge, advance model at posedge
    task automatic cycle(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic push, pop;
        logic [31:0] w;
        int nst;
        fetch_en = fe;
        redirect_valid = rv;
        redirect_pc = rpc;
        id_ready = rdy;
        @(negedge clk);
        check_model();
        w = mem[m_pc[7:2]];
        push = m_st == 1 && fe && !rv && q.size() < 4;
        pop = q.size() != 0 && rdy && !rv;
        if (m_st == 0) nst = fe ? 1 : 0;
        else if (m_st == 1) nst = !fe ? 0 : (push && w == 0) ? 2 : 1;
        else nst = rv ? (fe ? 1 : 0) : 2;
        if (rv) begin
            q.delete();
            m_pc = rpc & ~32'h3;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back('{m_pc, w});
                m_pc = m_pc + 32'd4;
            end
        end
        m_st = nst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 0;
        mem[0] = 32'h00100093;
        mem[1] = 32'h00200113;
        mem[2] = 32'h002081b3;
        mem[3] = 32'h40308233;
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("rst_wrap_addr", imem_addr_w, 32'hFFFF_FFFC);
        #2 rst_n = 1;
        @(posedge clk);
        #1;
        repeat (10) cycle(1, 0, 0, 1);
        chk("basic_halted", 32'(halted), 1);
        chk("basic_addr", imem_addr, 32'h14);
        cycle(1, 1, 32'h8, 1);
        chk("unhalt_halted", 32'(halted), 0);
        chk("unhalt_addr", imem_addr, 32'h8);
        cycle(1, 0, 0, 1);
        chk("unhalt_pc", id_pc, 32'h8);
        chk("unhalt_instr", id_instr, 32'h002081b3);
        cycle(1, 1, 0, 0);
        repeat (6) cycle(1, 0, 0, 0);
        chk("bp_count", 32'(fifo_count), 4);
        chk("bp_addr", imem_addr, 32'h10);
        chk("bp_pc", id_pc, 32'h0);
        chk("bp_instr", id_instr, 32'h00100093);
        cycle(1, 0, 0, 1);
        chk("bp_pop_count", 32'(fifo_count), 3);
        chk("bp_pop_pc", id_pc, 32'h4);
        chk("bp_pop_instr", id_instr, 32'h00200113);
        cycle(1, 0, 0, 1);
        chk("bp_resume_count", 32'(fifo_count), 3);
        cycle(1, 1, 0, 0);
        repeat (5) cycle(1, 0, 0, 0);
        chk("full_before_redir", 32'(fifo_count), 4);
        cycle(1, 1, 32'h6, 1);
        chk("redir_count", 32'(fifo_count), 0);
        chk("redir_valid", 32'(id_valid), 0);
        chk("redir_addr", imem_addr, 32'h4);
        cycle(1, 0, 0, 0);
        chk("redir_valid2", 32'(id_valid), 1);
        chk("redir_pc2", id_pc, 32'h4);
        for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h1);
        repeat (400) cycle($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 2) != 0);
        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 10 && q.size() != 3; i++) cycle(1, 0, 0, 0);
        chk("pre_reset_count", 32'(fifo_count), 3);
        fetch_en = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_valid", 32'(id_valid), 0);
        chk("arst_count", 32'(fifo_count), 0);
        chk("arst_halted", 32'(halted), 0);
        chk("arst_addr", imem_addr, 32'h0);
        model_reset();
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        repeat (4) cycle(1, 0, 0, 1);
        fetch_en = 0;
        #2 rst_n = 0;
        #1;
        chk("wrap_rst_addr", imem_addr_w, 32'hFFFF_FFFC);
        model_reset();
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0, 1);
            if (id_valid_w) got.push_back('{id_pc_w, id_instr_w});
        end
        chk("wrap_heads", 32'(got.size() >= 3), 1);
        if (got.size() >= 3) begin
            chk("wrap_pc0", got[0].pc, 32'hFFFF_FFFC);
            chk("wrap_pc1", got[1].pc, 32'h0);
            chk("wrap_pc2", got[2].pc, 32'h4);
            chk("wrap_in0", got[0].instr, mem[63]);
            chk("wrap_in1", got[1].instr, mem[0]);
            chk("wrap_in2", got[2].instr, mem[1]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
